param_commit_scheduler: RTL and testbench
=========================================

Name: param_commit_scheduler

Overview:
- Sequences host parameter updates (lce, tau, ltp, ltd, p_delta, syn_gain, clk_divider, ...) into the neuron/synapse/muscle datapath so that changes land only at 1 ms simulation-tick boundaries.
- Host trigger strobes stage a 32-bit word per slot. On each sim tick a scan FSM commits pending slots to the live parameter bank, one slot per cycle, in a deterministic order.
- Replaces free-running per-trigger registers with a single clocked, tick-aligned controller.

Parameters:
- NSLOT, 8, number of parameter slots (1..16).
- SW, 4, slot index width; must satisfy 2^SW >= NSLOT.
- RESET_VALS, {NSLOT{32'd0}}, flattened reset value per slot; slot i is RESET_VALS[i*32 +: 32].

Ports:
- clk  in  1  neuron_clk domain clock.
- reset  in  1  asynchronous, active-high.
- trig  in  NSLOT  one-cycle update strobes, synchronous to clk; bit i targets slot i.
- data_in  in  32  word staged by any trig bit asserted this cycle.
- sim_tick  in  1  one-cycle pulse marking a 1 ms simulation boundary.
- clear_err  in  1  clears the sticky error flags.
- param_bank  out  NSLOT*32  live parameters; slot i is [i*32 +: 32].
- pending  out  NSLOT  slot i staged but not yet committed.
- commit_strobe  out  1  pulse; a slot was committed this cycle.
- commit_slot  out  SW  index of the committed slot; valid only with commit_strobe.
- commit_done  out  1  pulse; scan pass finished.
- busy  out  1  high in SCAN and DONE.
- overwrite_err  out  1  sticky; a trig hit a slot that was already pending.
- tick_overrun  out  1  sticky; sim_tick arrived while busy.

Behaviour:
- Reset (async):
  - param_bank = RESET_VALS; staging = RESET_VALS.
  - pending, commit_strobe, commit_slot, commit_done, busy, overwrite_err and tick_overrun are all 0.
  - FSM goes to IDLE and the scan index to 0.
  - Reset mid-scan abandons the pass; no partial commits survive.
- Staging, in any state:
  - trig[i] writes staging[i] = data_in and sets pending[i].
  - Several trig bits in one cycle all stage the same data_in.
  - trig[i] while pending[i] is already 1: overwrite staging, set overwrite_err.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: sim_tick -> SCAN with idx = 0 on the next cycle.
  - SCAN:
    - Each cycle, if pending[idx]: param_bank[idx] <= staging[idx], clear pending[idx], assert commit_strobe with commit_slot = idx (registered, same cycle as the bank update).
    - idx increments every cycle. At idx = NSLOT-1 go to DONE.
    - The scan always takes exactly NSLOT cycles, whether or not slots are pending.
  - DONE: commit_done = 1 for one cycle, then IDLE.
- Latency: sim_tick sampled at edge T -> slot k commits at edge T+1+k -> visible on param_bank from T+1+k. A pass occupies NSLOT+1 cycles after the tick.
- Late triggers during SCAN:
  - Slot index greater than the current idx: committed in this pass.
  - Slot index less than the current idx: stays pending until the next tick.
- Simultaneous trig[idx] and commit of idx:
  - The commit takes the old staging value.
  - pending[idx] stays 1 and the new word is held for the next tick.
  - overwrite_err is set, because the slot was pending.
- sim_tick while busy: ignored, tick_overrun set. With 128 neuron_clk cycles per tick this is unreachable for NSLOT <= 16.
- Error flags:
  - clear_err clears both sticky flags.
  - clear_err together with a new error event in the same cycle leaves the flag set (set wins).
- Slots with index >= NSLOT do not exist; idx never exceeds NSLOT-1.

Decomposition:
- Shared package: FSM state encoding (IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2), the SLOT_LCE..SLOT_CLKDIV index constants, and the default RESET_VALS words:
  - lce 32'h3f8ccccd
  - tau 32'h3cf5c28f
  - syn_gain 32'd1
- One natural sub-module, param_slot: holds staging, pending and live registers plus the overwrite detect for one slot, instantiated NSLOT times. The top holds only the FSM and scan index.

Test Plan:
- Reset with RESET_VALS slot1 = 32'h3cf5c28f -> param_bank[63:32] = 32'h3cf5c28f, pending = 0, busy = 0.
- trig[3] with data 32'h0000_00AA, then sim_tick at edge T -> commit_strobe with commit_slot = 3 at T+4, slot3 = 32'hAA, commit_done at T+9 (NSLOT = 8), pending = 0.
- trig = 8'b0000_0101 with data 32'h55 in one cycle -> slots 0 and 2 both hold 32'h55 after the next pass; two strobes, at T+1 and T+3.
- During SCAN at idx = 4: trig[2] = 32'h11 and trig[6] = 32'h22 -> slot6 commits 32'h22 this pass; slot2 stays pending and commits at the next tick.
- trig[5] = 32'h1 then trig[5] = 32'h2 before the tick -> overwrite_err = 1, slot5 commits 32'h2; clear_err -> overwrite_err = 0.
- Extra sim_tick at T+2 -> tick_overrun = 1, no second pass. Assert reset at T+3 -> param_bank = RESET_VALS, FSM in IDLE, all flags 0.

Source files
------------

// File: rtl/param_commit_scheduler_pkg.sv
// Shared types and constants for the tick-aligned parameter commit scheduler.
package param_commit_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slot assignment of the host-visible parameters
  localparam int SLOT_LCE     = 0;
  localparam int SLOT_TAU     = 1;
  localparam int SLOT_LTP     = 2;
  localparam int SLOT_LTD     = 3;
  localparam int SLOT_PDELTA  = 4;
  localparam int SLOT_SYNGAIN = 5;
  localparam int SLOT_MUSCLE  = 6;
  localparam int SLOT_CLKDIV  = 7;

  localparam logic [31:0] RST_LCE     = 32'h3f8ccccd;  // 1.1f
  localparam logic [31:0] RST_TAU     = 32'h3cf5c28f;  // 0.03f
  localparam logic [31:0] RST_SYNGAIN = 32'd1;

  // Power-on bank for the 8-slot configuration, slot 0 in the low word
  localparam logic [8*32-1:0] DEFAULT_RESET_VALS = {
    32'd0, 32'd0, RST_SYNGAIN, 32'd0, 32'd0, 32'd0, RST_TAU, RST_LCE
  };

endpackage

// File: rtl/param_commit_scheduler_if.sv
// Host/datapath bundle of the parameter commit scheduler.
interface param_commit_scheduler_if #(
  parameter int NSLOT = 8,
  parameter int SW    = 4
);
  logic [NSLOT-1:0]    trig;
  logic [31:0]         data_in;
  logic                sim_tick;
  logic                clear_err;
  logic [NSLOT*32-1:0] param_bank;
  logic [NSLOT-1:0]    pending;
  logic                commit_strobe;
  logic [SW-1:0]       commit_slot;
  logic                commit_done;
  logic                busy;
  logic                overwrite_err;
  logic                tick_overrun;

  modport master (
    output trig, data_in, sim_tick, clear_err,
    input  param_bank, pending, commit_strobe, commit_slot, commit_done,
           busy, overwrite_err, tick_overrun
  );

  modport slave (
    input  trig, data_in, sim_tick, clear_err,
    output param_bank, pending, commit_strobe, commit_slot, commit_done,
           busy, overwrite_err, tick_overrun
  );
endinterface

// File: rtl/param_commit_scheduler_slot.sv
// One parameter slot: staging word, pending flag and live word.
module param_slot
  import param_commit_scheduler_pkg::*;
#(
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  input  logic [31:0] data_in,
  input  logic        commit,   // scan is at this slot this cycle
  output logic [31:0] live,
  output logic        pending,
  output logic        ovw       // trig landed on an already-pending slot
);
  logic [31:0] staging_q, staging_d, live_q, live_d;
  logic        pending_q, pending_d;

  // Commit moves the old staging word; a same-cycle trig re-stages and keeps pending
  always_comb begin
    staging_d = staging_q;
    live_d    = live_q;
    pending_d = pending_q;
    if (commit && pending_q) begin
      live_d    = staging_q;
      pending_d = 1'b0;
    end
    if (trig) begin
      staging_d = data_in;
      pending_d = 1'b1;
    end
  end

  // Slot state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_q <= RST_VAL;
      live_q    <= RST_VAL;
      pending_q <= 1'b0;
    end else begin
      staging_q <= staging_d;
      live_q    <= live_d;
      pending_q <= pending_d;
    end
  end

  assign live    = live_q;
  assign pending = pending_q;
  assign ovw     = trig & pending_q;
endmodule

// File: rtl/param_commit_scheduler.sv
// Tick-aligned commit controller: on sim_tick, scans all slots once and
// moves pending staged words into the live bank, one slot per cycle.
module param_commit_scheduler
  import param_commit_scheduler_pkg::*;
#(
  parameter int                  NSLOT      = 8,
  parameter int                  SW         = 4,
  parameter logic [NSLOT*32-1:0] RESET_VALS = {NSLOT{32'd0}}
) (
  input logic                     clk,
  input logic                     reset,
  param_commit_scheduler_if.slave bus
);
  localparam logic [SW-1:0] LAST = SW'(NSLOT - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic          ovw_err_q, ovw_err_d;
  logic          overrun_q, overrun_d;
  logic [NSLOT-1:0] sel, pend, ovw_hit;
  logic          busy;

  assign busy = (state_q != ST_IDLE);

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    assign sel[gi] = (state_q == ST_SCAN) && (idx_q == SW'(gi));
    param_slot #(.RST_VAL(RESET_VALS[gi*32 +: 32])) u_slot (
      .clk     (clk),
      .reset   (reset),
      .trig    (bus.trig[gi]),
      .data_in (bus.data_in),
      .commit  (sel[gi]),
      .live    (bus.param_bank[gi*32 +: 32]),
      .pending (pend[gi]),
      .ovw     (ovw_hit[gi])
    );
  end

  // Scan FSM next state, commit pulses and sticky error flags
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    strobe_d  = |(sel & pend);
    slot_d    = strobe_d ? idx_q : '0;
    ovw_err_d = (|ovw_hit) | (ovw_err_q & ~bus.clear_err);
    overrun_d = (bus.sim_tick & busy) | (overrun_q & ~bus.clear_err);
    case (state_q)
      ST_IDLE: if (bus.sim_tick) begin
        state_d = ST_SCAN;
        idx_d   = '0;
      end
      ST_SCAN: if (idx_q == LAST) begin
        state_d = ST_DONE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
      slot_q    <= '0;
      done_q    <= 1'b0;
      ovw_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      slot_q    <= slot_d;
      done_q    <= done_d;
      ovw_err_q <= ovw_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.pending       = pend;
  assign bus.commit_strobe = strobe_q;
  assign bus.commit_slot   = slot_q;
  assign bus.commit_done   = done_q;
  assign bus.busy          = busy;
  assign bus.overwrite_err = ovw_err_q;
  assign bus.tick_overrun  = overrun_q;
endmodule

// File: tb/tb_param_commit_scheduler.sv
// Bench for param_commit_scheduler: directed scenarios plus a randomized run
// against a slot/tick reference model.
module tb_param_commit_scheduler;
  import param_commit_scheduler_pkg::*;

  localparam int NSLOT = 8;
  localparam int SW    = 4;
  localparam logic [NSLOT*32-1:0] RV = DEFAULT_RESET_VALS;

  logic clk, reset;
  int   checks = 0;
  int   errors = 0;

  param_commit_scheduler_if #(.NSLOT(NSLOT), .SW(SW)) bus ();

  param_commit_scheduler #(.NSLOT(NSLOT), .SW(SW), .RESET_VALS(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slot contents plus the position of the scan in the pass
  // (-1 idle, 0..NSLOT-1 slot visited at the next edge, NSLOT finishing).
  logic [31:0] m_stage [NSLOT];
  logic [31:0] m_bank  [NSLOT];
  bit          m_pend  [NSLOT];
  int          m_pos, m_slot;
  bit          m_strobe, m_done, m_ovw, m_ovr;

  function automatic void model_reset();
    for (int i = 0; i < NSLOT; i++) begin
      m_stage[i] = RV[i*32 +: 32];
      m_bank[i]  = RV[i*32 +: 32];
      m_pend[i]  = 1'b0;
    end
    m_pos = -1; m_slot = 0;
    m_strobe = 0; m_done = 0; m_ovw = 0; m_ovr = 0;
  endfunction

  function automatic void model_step(input logic [NSLOT-1:0] t, input logic [31:0] d,
                                     input logic tk, input logic cl);
    bit was_busy = (m_pos != -1);
    bit ovw_ev = 0;
    for (int i = 0; i < NSLOT; i++) if (t[i] && m_pend[i]) ovw_ev = 1;
    m_strobe = 0; m_done = 0;
    if (m_pos >= 0 && m_pos < NSLOT && m_pend[m_pos]) begin
      m_bank[m_pos] = m_stage[m_pos];
      m_pend[m_pos] = 0;
      m_strobe = 1; m_slot = m_pos;
    end
    for (int i = 0; i < NSLOT; i++) if (t[i]) begin
      m_stage[i] = d; m_pend[i] = 1;
    end
    m_ovw = ovw_ev | (m_ovw & !cl);
    m_ovr = (tk & was_busy) | (m_ovr & !cl);
    if (m_pos == -1)        begin if (tk) m_pos = 0; end
    else if (m_pos < NSLOT) m_pos++;
    else begin m_pos = -1; m_done = 1; end
  endfunction

  function automatic logic [NSLOT*32-1:0] m_bank_flat();
    logic [NSLOT*32-1:0] v;
    for (int i = 0; i < NSLOT; i++) v[i*32 +: 32] = m_bank[i];
    return v;
  endfunction

  function automatic logic [NSLOT-1:0] m_pend_vec();
    logic [NSLOT-1:0] v;
    for (int i = 0; i < NSLOT; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock: drive inputs, let the DUT sample them, advance the model, sample #1 later
  task automatic cyc(input logic [NSLOT-1:0] t, input logic [31:0] d,
                     input logic tk, input logic cl);
    bus.trig = t; bus.data_in = d; bus.sim_tick = tk; bus.clear_err = cl;
    @(posedge clk);
    model_step(t, d, tk, cl);
    #1;
    bus.trig = '0; bus.data_in = '0; bus.sim_tick = 1'b0; bus.clear_err = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.param_bank[63:32] !== 32'h3cf5c28f) begin errors++; $display("FAIL reset_slot1 got %h exp %h", bus.param_bank[63:32], 32'h3cf5c28f); end
    checks++; if (bus.param_bank !== RV) begin errors++; $display("FAIL reset_bank got %h exp %h", bus.param_bank, RV); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h exp 00", bus.pending); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if ({bus.commit_strobe, bus.commit_done, bus.overwrite_err, bus.tick_overrun} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {bus.commit_strobe, bus.commit_done, bus.overwrite_err, bus.tick_overrun}); end
  endtask

  task automatic test_single_commit();
    cyc(8'h08, 32'h0000_00AA, 0, 0);
    cyc('0, '0, 1, 0);                       // tick sampled at edge T
    for (int c = 1; c <= 9; c++) begin
      cyc('0, '0, 0, 0);
      checks++; if (bus.commit_strobe !== 1'(c == 4)) begin errors++; $display("FAIL single_strobe T+%0d got %b exp %b", c, bus.commit_strobe, c == 4); end
      checks++; if (bus.commit_done !== 1'(c == 9)) begin errors++; $display("FAIL single_done T+%0d got %b exp %b", c, bus.commit_done, c == 9); end
      if (c == 4) begin
        checks++; if (bus.commit_slot !== 4'd3) begin errors++; $display("FAIL single_slot got %0d exp 3", bus.commit_slot); end
        checks++; if (bus.param_bank[127:96] !== 32'hAA) begin errors++; $display("FAIL single_value got %h exp aa", bus.param_bank[127:96]); end
      end
    end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL single_pending got %h exp 00", bus.pending); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_multi_trig();
    cyc(8'b0000_0101, 32'h55, 0, 0);
    cyc('0, '0, 1, 0);
    for (int c = 1; c <= 9; c++) begin
      cyc('0, '0, 0, 0);
      checks++; if (bus.commit_strobe !== 1'(c == 1 || c == 3)) begin errors++; $display("FAIL multi_strobe T+%0d got %b", c, bus.commit_strobe); end
    end
    checks++; if (bus.param_bank[31:0] !== 32'h55 || bus.param_bank[95:64] !== 32'h55) begin
      errors++; $display("FAIL multi_values got %h/%h exp 55/55", bus.param_bank[31:0], bus.param_bank[95:64]); end
  endtask

  task automatic test_late_trig();
    cyc('0, '0, 1, 0);                        // edge T
    for (int c = 1; c <= 4; c++) cyc('0, '0, 0, 0);
    cyc(8'h04, 32'h11, 0, 0);                 // edge T+5, scan at slot 4
    cyc(8'h40, 32'h22, 0, 0);                 // edge T+6, scan at slot 5
    cyc('0, '0, 0, 0);                        // edge T+7, slot 6 commits
    checks++; if (bus.commit_strobe !== 1'b1 || bus.commit_slot !== 4'd6) begin
      errors++; $display("FAIL late_slot6 strobe %b slot %0d exp 1/6", bus.commit_strobe, bus.commit_slot); end
    checks++; if (bus.param_bank[223:192] !== 32'h22) begin errors++; $display("FAIL late_value6 got %h exp 22", bus.param_bank[223:192]); end
    cyc('0, '0, 0, 0); cyc('0, '0, 0, 0);
    checks++; if (bus.pending !== 8'h04) begin errors++; $display("FAIL late_pending got %h exp 04", bus.pending); end
    cyc('0, '0, 1, 0);
    for (int c = 1; c <= 3; c++) cyc('0, '0, 0, 0);
    checks++; if (bus.commit_strobe !== 1'b1 || bus.commit_slot !== 4'd2 || bus.param_bank[95:64] !== 32'h11) begin
      errors++; $display("FAIL late_slot2 strobe %b slot %0d val %h exp 1/2/11", bus.commit_strobe, bus.commit_slot, bus.param_bank[95:64]); end
    for (int c = 4; c <= 9; c++) cyc('0, '0, 0, 0);
  endtask

  task automatic test_overwrite();
    cyc(8'h20, 32'h1, 0, 0);
    cyc(8'h20, 32'h2, 0, 0);
    checks++; if (bus.overwrite_err !== 1'b1) begin errors++; $display("FAIL ovw_set got %b exp 1", bus.overwrite_err); end
    cyc('0, '0, 1, 0);
    for (int c = 1; c <= 9; c++) begin
      cyc('0, '0, 0, 0);
      if (c == 6) begin
        checks++; if (bus.commit_strobe !== 1'b1 || bus.commit_slot !== 4'd5 || bus.param_bank[191:160] !== 32'h2) begin
          errors++; $display("FAIL ovw_commit strobe %b slot %0d val %h exp 1/5/2", bus.commit_strobe, bus.commit_slot, bus.param_bank[191:160]); end
      end
    end
    cyc('0, '0, 0, 1);
    checks++; if (bus.overwrite_err !== 1'b0) begin errors++; $display("FAIL ovw_clear got %b exp 0", bus.overwrite_err); end
    cyc(8'h20, 32'h3, 0, 0);
    cyc(8'h20, 32'h4, 0, 1);                  // new event with clear: set wins
    checks++; if (bus.overwrite_err !== 1'b1) begin errors++; $display("FAIL ovw_setwins got %b exp 1", bus.overwrite_err); end
    cyc('0, '0, 0, 1);
    checks++; if (bus.overwrite_err !== 1'b0) begin errors++; $display("FAIL ovw_clear2 got %b exp 0", bus.overwrite_err); end
  endtask

  task automatic test_collision();
    cyc(8'h02, 32'h77, 0, 0);
    cyc('0, '0, 1, 0);                        // edge T
    cyc('0, '0, 0, 0);                        // T+1 (slot 0 visited; slot 5 pending commits later)
    cyc(8'h02, 32'h99, 0, 0);                 // T+2, slot 1 commits while re-triggered
    checks++; if (bus.commit_strobe !== 1'b1 || bus.commit_slot !== 4'd1) begin
      errors++; $display("FAIL coll_strobe got %b/%0d exp 1/1", bus.commit_strobe, bus.commit_slot); end
    checks++; if (bus.param_bank[63:32] !== 32'h77) begin errors++; $display("FAIL coll_old got %h exp 77", bus.param_bank[63:32]); end
    checks++; if (bus.pending[1] !== 1'b1) begin errors++; $display("FAIL coll_pending got %b exp 1", bus.pending[1]); end
    checks++; if (bus.overwrite_err !== 1'b1) begin errors++; $display("FAIL coll_ovw got %b exp 1", bus.overwrite_err); end
    for (int c = 3; c <= 9; c++) cyc('0, '0, 0, 0);
    cyc('0, '0, 1, 1);
    cyc('0, '0, 0, 0); cyc('0, '0, 0, 0);
    checks++; if (bus.commit_slot !== 4'd1 || bus.param_bank[63:32] !== 32'h99) begin
      errors++; $display("FAIL coll_next slot %0d val %h exp 1/99", bus.commit_slot, bus.param_bank[63:32]); end
    for (int c = 3; c <= 9; c++) cyc('0, '0, 0, 0);
  endtask

  task automatic test_overrun_reset();
    int strobes = 0;
    cyc('0, '0, 1, 0);
    cyc('0, '0, 0, 0);
    cyc('0, '0, 1, 0);                        // extra tick at T+2
    checks++; if (bus.tick_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", bus.tick_overrun); end
    for (int c = 3; c <= 9; c++) cyc('0, '0, 0, 0);
    for (int c = 0; c < 12; c++) begin
      cyc('0, '0, 0, 0);
      strobes += int'(bus.busy);
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL ovr_nosecond busy_cycles %0d exp 0", strobes); end
    cyc('0, '0, 0, 1);
    cyc(8'h41, 32'hDEAD_BEEF, 0, 0);
    cyc('0, '0, 1, 0);                        // edge T
    cyc('0, '0, 0, 0);                        // T+1: slot 0 commits
    checks++; if (bus.param_bank[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_pre got %h exp deadbeef", bus.param_bank[31:0]); end
    cyc('0, '0, 1, 0);                        // T+2: overrun
    cyc('0, '0, 0, 0);                        // T+3
    apply_reset();
    checks++; if (bus.param_bank !== RV) begin errors++; $display("FAIL rst_mid_bank got %h exp %h", bus.param_bank, RV); end
    checks++; if ({bus.busy, bus.pending} !== 9'b0) begin errors++; $display("FAIL rst_mid_state got %b exp 0", {bus.busy, bus.pending}); end
    checks++; if ({bus.overwrite_err, bus.tick_overrun, bus.commit_strobe, bus.commit_done} !== 4'b0) begin
      errors++; $display("FAIL rst_mid_flags got %b exp 0000", {bus.overwrite_err, bus.tick_overrun, bus.commit_strobe, bus.commit_done}); end
  endtask

  task automatic test_random();
    logic [NSLOT-1:0] t;
    logic tk, cl;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      t  = ($urandom_range(0, 3) == 0) ? NSLOT'($urandom) : '0;
      tk = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 24) == 0);
      cyc(t, $urandom, tk, cl);
      checks++; if (bus.param_bank !== m_bank_flat()) begin errors++; $display("FAIL rnd_bank n=%0d got %h exp %h", n, bus.param_bank, m_bank_flat()); end
      checks++; if (bus.pending !== m_pend_vec()) begin errors++; $display("FAIL rnd_pending n=%0d got %h exp %h", n, bus.pending, m_pend_vec()); end
      checks++; if (bus.commit_strobe !== m_strobe) begin errors++; $display("FAIL rnd_strobe n=%0d got %b exp %b", n, bus.commit_strobe, m_strobe); end
      if (m_strobe) begin
        checks++; if (bus.commit_slot !== SW'(m_slot)) begin errors++; $display("FAIL rnd_slot n=%0d got %0d exp %0d", n, bus.commit_slot, m_slot); end
      end
      checks++; if (bus.commit_done !== m_done) begin errors++; $display("FAIL rnd_done n=%0d got %b exp %b", n, bus.commit_done, m_done); end
      checks++; if (bus.busy !== (m_pos != -1)) begin errors++; $display("FAIL rnd_busy n=%0d got %b exp %b", n, bus.busy, m_pos != -1); end
      checks++; if (bus.overwrite_err !== m_ovw) begin errors++; $display("FAIL rnd_ovw n=%0d got %b exp %b", n, bus.overwrite_err, m_ovw); end
      checks++; if (bus.tick_overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr n=%0d got %b exp %b", n, bus.tick_overrun, m_ovr); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.trig = '0; bus.data_in = '0; bus.sim_tick = 1'b0; bus.clear_err = 1'b0;
    model_reset();
    #3;
    test_reset();
    test_single_commit();
    test_multi_trig();
    test_late_trig();
    test_overwrite();
    test_collision();
    test_overrun_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
